// File: rtl/svc_uart_rx.sv
// svc_uart_rx: 8N1 UART receiver with mid-bit sampling, valid/ready byte output,
// framing-error and overrun pulses.
module svc_uart_rx #(
    parameter int CLOCK_FREQ = 25_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_pin,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       urx_frame_err,
    output logic       urx_overrun
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $fatal(1, "svc_uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_m;
    logic          rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            urx_valid     <= 1'b0;
            urx_data      <= '0;
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
        end else begin
            rx_m          <= urx_pin;
            rx_s          <= rx_m;
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
            if (urx_valid && urx_ready)
                urx_valid <= 1'b0;
            case (state)
                IDLE:
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= HALF_LD;
                    end
                START:
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (rx_s)
                        state <= IDLE;
                    else begin
                        state <= DATA;
                        cnt   <= BIT_LD;
                        idx   <= '0;
                    end
                DATA:
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else begin
                        shreg[idx] <= rx_s;
                        cnt        <= BIT_LD;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end
                STOP:
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (rx_s) begin
                        // Returning to IDLE at stop mid-bit leaves half a bit to catch the next start edge.
                        state <= IDLE;
                        if (!urx_valid || urx_ready) begin
                            urx_data  <= shreg;
                            urx_valid <= 1'b1;
                        end else
                            urx_overrun <= 1'b1;
                    end else begin
                        urx_frame_err <= 1'b1;
                        state         <= BREAK;
                    end
                BREAK:
                    if (rx_s)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule
